// File: rtl/case_seq_pkg.sv
// rtl/case_seq_pkg.sv - shared types and constants for the case_mod select sequencer
//
// Purpose: FSM state encoding, hold-counter width and a helper that turns
//          the HOLD parameter into the counter reload value.
// Ports:   none (package).
package case_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int HOLD_MAX = 255;
   localparam int CNTW     = 8;

   // Counter reload for a given hold time; the counter counts down to zero,
   // so HOLD cycles of DRIVE need HOLD-1 loaded. Out-of-range holds are clamped.
   function automatic logic [CNTW-1:0] hold_load(input int hold);
      int h;
      h = hold;
      if (h < 1) h = 1;
      if (h > HOLD_MAX) h = HOLD_MAX;
      return CNTW'(h - 1);
   endfunction

endpackage

// File: rtl/case_sel_sequencer_if.sv
// rtl/case_sel_sequencer_if.sv - requester/datapath bundle for the case_mod select sequencer
//
// Purpose: groups the two request channels, the case_mod feedback and the
//          sequencer outputs.
// Ports:   req0/code0, req1/code1  requests and 2-bit select codes
//          b_in                    case_mod output b (SIZE bits)
//          sel                     select to case_mod input a
//          gnt0/gnt1, done, busy   access status
//          result                  captured b_in of the last completed access
// Modports: master = requester/datapath side, slave = sequencer side.
interface case_sel_sequencer_if #(
   parameter int SIZE = 3
);

   logic            req0;
   logic [1:0]      code0;
   logic            req1;
   logic [1:0]      code1;
   logic [SIZE-1:0] b_in;
   logic [1:0]      sel;
   logic            gnt0;
   logic            gnt1;
   logic            done;
   logic [SIZE-1:0] result;
   logic            busy;

   modport master (
      output req0, code0, req1, code1, b_in,
      input  sel, gnt0, gnt1, done, result, busy
   );

   modport slave (
      input  req0, code0, req1, code1, b_in,
      output sel, gnt0, gnt1, done, result, busy
   );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
//
// Purpose: chooses one of two requesters; ptr only matters when both request.
// Ports:   req0, req1  requests
//          ptr         0 favours requester 0, 1 favours requester 1
//          win_valid   at least one request present
//          win_id      index of the winner (0 or 1)
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic win_valid,
   output logic win_id
);

   assign win_valid = req0 | req1;
   // A lone requester wins outright; ptr only breaks ties.
   assign win_id    = (req0 & req1) ? ptr : req1;

endmodule

// File: rtl/case_sel_sequencer.sv
// rtl/case_sel_sequencer.sv - arbitrates two requesters for one case_mod selector and sequences each access
//
// Purpose: latches the winner's code onto sel, holds it HOLD cycles, then
//          captures b_in into result and pulses done.
// Ports:   clock  single clock, posedge
//          reset  synchronous active-high reset
//          bus    case_sel_sequencer_if.slave (requests, b_in, sel, gnt0/1,
//                 done, result, busy)
// Params:  SIZE   width of b_in / result
//          HOLD   cycles sel is held before b_in is sampled (1..255)
module case_sel_sequencer
   import case_seq_pkg::*;
#(
   parameter int SIZE = 3,
   parameter int HOLD = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   case_sel_sequencer_if.slave   bus
);

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            ptr_q, ptr_d;
   logic            win_q, win_d;
   logic [1:0]      sel_q, sel_d;
   logic            gnt0_q, gnt0_d;
   logic            gnt1_q, gnt1_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic [SIZE-1:0] result_q, result_d;

   logic            win_valid;
   logic            win_id;
   logic            req_owned;

   rr_arb2 u_arb (
      .req0      (bus.req0),
      .req1      (bus.req1),
      .ptr       (ptr_q),
      .win_valid (win_valid),
      .win_id    (win_id)
   );

   // Request line of whoever currently owns the datapath.
   assign req_owned = win_q ? bus.req1 : bus.req0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ptr_q    <= 1'b0;
         win_q    <= 1'b0;
         sel_q    <= 2'b00;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         sel_q    <= sel_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      sel_d    = sel_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            gnt0_d = 1'b0;
            gnt1_d = 1'b0;
            busy_d = 1'b0;
            if (win_valid) begin
               win_d   = win_id;
               sel_d   = win_id ? bus.code1 : bus.code0;
               gnt0_d  = ~win_id;
               gnt1_d  = win_id;
               busy_d  = 1'b1;
               cnt_d   = hold_load(HOLD);
               state_d = DRIVE;
            end
         end

         DRIVE: begin
            // A withdrawn request ends the access before any capture.
            if (!req_owned) begin
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               busy_d  = 1'b0;
               ptr_d   = ~win_q;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
               result_d = bus.b_in;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end

         DONE: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            busy_d  = 1'b0;
            ptr_d   = ~win_q;
            state_d = IDLE;
         end

         default: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.sel    = sel_q;
   assign bus.gnt0   = gnt0_q;
   assign bus.gnt1   = gnt1_q;
   assign bus.done   = done_q;
   assign bus.busy   = busy_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_case_sel_sequencer.sv
// tb/tb_case_sel_sequencer.sv - self-checking bench for case_sel_sequencer (HOLD=4 and HOLD=1 builds)
module tb_case_sel_sequencer;

   logic clock;
   logic reset;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   case_sel_sequencer_if #(.SIZE(3)) if4 ();
   case_sel_sequencer_if #(.SIZE(3)) if1 ();

   // case_mod stand-in: b = {1, a}
   assign if4.b_in = {1'b1, if4.sel};
   assign if1.b_in = {1'b1, if1.sel};

   case_sel_sequencer #(.SIZE(3), .HOLD(4)) u_seq4 (
      .clock (clock),
      .reset (reset),
      .bus   (if4)
   );

   case_sel_sequencer #(.SIZE(3), .HOLD(1)) u_seq1 (
      .clock (clock),
      .reset (reset),
      .bus   (if1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- access-level model ----------------
   // owner = -1 when idle; age counts cycles since the grant (1..HOLD are
   // the hold cycles, HOLD+1 is the done cycle).
   int         hold_of [2] = '{4, 1};
   int         m_owner [2];
   int         m_age   [2];
   bit         m_ptr   [2];
   logic [1:0] m_sel   [2];
   logic [2:0] m_res   [2];
   bit         m_done  [2];
   bit         m_started = 1'b0;

   task automatic m_step(input int k, input logic rst, input logic r0, input logic r1,
                         input logic [1:0] c0, input logic [1:0] c1);
      int  h;
      int  w;
      logic owned;
      h = hold_of[k];
      if (rst) begin
         m_owner[k] = -1; m_age[k] = 0; m_ptr[k] = 1'b0;
         m_sel[k] = 2'b00; m_res[k] = 3'b000; m_done[k] = 1'b0;
      end else if (m_owner[k] < 0) begin
         m_done[k] = 1'b0;
         if (r0 || r1) begin
            if (r0 && r1) w = m_ptr[k] ? 1 : 0;
            else          w = r1 ? 1 : 0;
            m_owner[k] = w;
            m_age[k]   = 1;
            m_sel[k]   = (w == 1) ? c1 : c0;
         end
      end else if (m_age[k] <= h) begin
         owned = (m_owner[k] == 1) ? r1 : r0;
         if (!owned) begin
            m_ptr[k]   = (m_owner[k] == 0);
            m_owner[k] = -1;
         end else if (m_age[k] == h) begin
            m_res[k]  = {1'b1, m_sel[k]};
            m_done[k] = 1'b1;
            m_age[k]++;
         end else begin
            m_age[k]++;
         end
      end else begin
         m_done[k]  = 1'b0;
         m_ptr[k]   = (m_owner[k] == 0);
         m_owner[k] = -1;
      end
   endtask

   always @(posedge clock) begin
      if (reset) m_started = 1'b1;
      m_step(0, reset, if4.req0, if4.req1, if4.code0, if4.code1);
      m_step(1, reset, if1.req0, if1.req1, if1.code0, if1.code1);
   end

   // Compare every cycle, on the falling edge.
   always @(negedge clock) begin
      if (m_started) begin
         for (int k = 0; k < 2; k++) begin
            logic [1:0] s;
            logic [2:0] r;
            logic g0, g1, d, b;
            if (k == 0) begin
               s = if4.sel; r = if4.result; g0 = if4.gnt0; g1 = if4.gnt1; d = if4.done; b = if4.busy;
            end else begin
               s = if1.sel; r = if1.result; g0 = if1.gnt0; g1 = if1.gnt1; d = if1.done; b = if1.busy;
            end
            chk($sformatf("model_sel[%0d]", k),    32'(s),  32'(m_sel[k]));
            chk($sformatf("model_result[%0d]", k), 32'(r),  32'(m_res[k]));
            chk($sformatf("model_gnt0[%0d]", k),   32'(g0), 32'(m_owner[k] == 0));
            chk($sformatf("model_gnt1[%0d]", k),   32'(g1), 32'(m_owner[k] == 1));
            chk($sformatf("model_done[%0d]", k),   32'(d),  32'(m_done[k]));
            chk($sformatf("model_busy[%0d]", k),   32'(b),  32'(m_owner[k] >= 0));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_done(input int k, input int maxc, output int cyc);
      cyc = -1;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge clock);
         if (((k == 0) ? if4.done : if1.done) === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   int c;

   initial begin
      reset = 1'b1;
      if4.req0 = 1'b0; if4.req1 = 1'b0; if4.code0 = 2'b00; if4.code1 = 2'b00;
      if1.req0 = 1'b0; if1.req1 = 1'b0; if1.code0 = 2'b00; if1.code1 = 2'b00;
      tick(2);
      chk("rst_sel",    32'(if4.sel),    32'd0);
      chk("rst_busy",   32'(if4.busy),   32'd0);
      chk("rst_result", 32'(if4.result), 32'd0);
      reset = 1'b0;

      // 1: single request, code 10
      if4.req0 = 1'b1; if4.code0 = 2'b10;
      tick(1);
      chk("t1_gnt0", 32'(if4.gnt0), 32'd1);
      chk("t1_sel",  32'(if4.sel),  32'd2);
      if4.code0 = 2'b01;           // later code changes must be ignored
      wait_done(0, 10, c);
      chk("t1_done_latency", 32'(c + 1), 32'd5);
      chk("t1_result", 32'(if4.result), 32'h6);
      if4.req0 = 1'b0;
      tick(1);
      chk("t1_idle_gnt0", 32'(if4.gnt0), 32'd0);
      chk("t1_idle_sel",  32'(if4.sel),  32'd2);

      // 2: simultaneous requests after reset, both held
      reset = 1'b1; tick(1); reset = 1'b0;
      if4.req0 = 1'b1; if4.code0 = 2'b01;
      if4.req1 = 1'b1; if4.code1 = 2'b11;
      tick(1);
      chk("t2_first_gnt0", 32'(if4.gnt0), 32'd1);
      chk("t2_first_gnt1", 32'(if4.gnt1), 32'd0);
      wait_done(0, 10, c);
      chk("t2_first_lat", 32'(c), 32'd4);
      chk("t2_first_result", 32'(if4.result), 32'h5);
      tick(1);
      chk("t2_gap_busy", 32'(if4.busy), 32'd0);
      tick(1);
      chk("t2_second_gnt1", 32'(if4.gnt1), 32'd1);
      chk("t2_second_sel",  32'(if4.sel),  32'd3);
      wait_done(0, 10, c);
      chk("t2_second_result", 32'(if4.result), 32'h7);
      if4.req0 = 1'b0; if4.req1 = 1'b0;
      tick(1);

      // 3: req0 alone leaves ptr=1, so a tie then goes to req1
      if4.req0 = 1'b1; if4.code0 = 2'b10;
      tick(1);
      wait_done(0, 10, c);
      chk("t3_solo_result", 32'(if4.result), 32'h6);
      if4.req0 = 1'b0;
      tick(1);
      if4.req0 = 1'b1; if4.code0 = 2'b01;
      if4.req1 = 1'b1; if4.code1 = 2'b11;
      tick(1);
      chk("t3_tie_gnt1", 32'(if4.gnt1), 32'd1);
      chk("t3_tie_gnt0", 32'(if4.gnt0), 32'd0);
      wait_done(0, 10, c);
      chk("t3_tie_result", 32'(if4.result), 32'h7);
      if4.req0 = 1'b0; if4.req1 = 1'b0;
      tick(1);

      // 4: req1 aborts in its second DRIVE cycle
      if4.req1 = 1'b1; if4.code1 = 2'b01;
      tick(2);
      if4.req1 = 1'b0;
      tick(1);
      chk("t4_abort_busy",   32'(if4.busy),   32'd0);
      chk("t4_abort_gnt1",   32'(if4.gnt1),   32'd0);
      chk("t4_abort_done",   32'(if4.done),   32'd0);
      chk("t4_abort_result", 32'(if4.result), 32'h7);
      if4.req0 = 1'b1; if4.code0 = 2'b00;
      if4.req1 = 1'b1; if4.code1 = 2'b10;
      tick(1);
      chk("t4_ptr0_gnt0", 32'(if4.gnt0), 32'd1);
      wait_done(0, 10, c);
      chk("t4_after_result", 32'(if4.result), 32'h4);
      if4.req0 = 1'b0; if4.req1 = 1'b0;
      tick(1);

      // 5: reset pulse mid-DRIVE
      if4.req0 = 1'b1; if4.code0 = 2'b01;
      tick(2);
      reset = 1'b1;
      tick(1);
      chk("t5_rst_sel",    32'(if4.sel),    32'd0);
      chk("t5_rst_gnt0",   32'(if4.gnt0),   32'd0);
      chk("t5_rst_busy",   32'(if4.busy),   32'd0);
      chk("t5_rst_done",   32'(if4.done),   32'd0);
      chk("t5_rst_result", 32'(if4.result), 32'd0);
      reset = 1'b0; if4.req0 = 1'b0;
      tick(1);
      chk("t5_post_done", 32'(if4.done), 32'd0);

      // 6: HOLD=1 build
      if1.req0 = 1'b1; if1.code0 = 2'b00;
      tick(1);
      chk("t6_gnt0", 32'(if1.gnt0), 32'd1);
      wait_done(1, 10, c);
      chk("t6_done_latency", 32'(c + 1), 32'd2);
      chk("t6_result", 32'(if1.result), 32'h4);
      if1.req0 = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
